// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MIPS memory-access stage:
//   - bit offsets of the packed EX/MEM (139-bit) and MEM/WB (38-bit) buses
//   - MemToReg select encodings
//   - memory-stage FSM state encoding
//   - helper to pack a MEM/WB word
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int EXM_W          = 139;
    localparam int MWB_W          = 38;
    localparam int DATA_W         = 32;

    // EX/MEM field offsets
    localparam int EXM_WDATA_LSB  = 0;
    localparam int EXM_ALU_LSB    = 32;
    localparam int EXM_RD_LSB     = 64;
    localparam int EXM_MEMREAD    = 69;
    localparam int EXM_MEMWRITE   = 70;
    localparam int EXM_REGWRITE   = 71;
    localparam int EXM_MTR_LSB    = 72;
    localparam int EXM_PC4_LSB    = 74;
    localparam int EXM_LUDATA_LSB = 106;
    localparam int EXM_LUOP       = 138;

    // MEM/WB field offsets
    localparam int MWB_DATA_LSB   = 0;
    localparam int MWB_RD_LSB     = 32;
    localparam int MWB_REGWRITE   = 37;

    // MemToReg encodings; the fourth code writes zero
    localparam logic [1:0] MTR_ALU  = 2'd0;
    localparam logic [1:0] MTR_MEM  = 2'd1;
    localparam logic [1:0] MTR_PC4  = 2'd2;
    localparam logic [1:0] MTR_ZERO = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    function automatic logic [MWB_W-1:0] pack_mem_wb(
        input logic              reg_write,
        input logic [4:0]        dest,
        input logic [DATA_W-1:0] data
    );
        return {reg_write, dest, data};
    endfunction

endpackage

// File: rtl/mem_wb_select.sv
// -----------------------------------------------------------------------------
// mem_wb_select
// Combinational write-back value mux. LUOp has priority over MemToReg.
// Ports:
//   lu_op       in   1   select lu_data unconditionally
//   mem_to_reg  in   2   00 ALU, 01 memory, 10 PC+4, 11 zero
//   alu_result  in  32   ALU result
//   mem_rdata   in  32   load data from memory
//   pc_plus4    in  32   return address
//   lu_data     in  32   upper-immediate data
//   wb_data     out 32   selected write-back value
// -----------------------------------------------------------------------------
module mem_wb_select
    import mem_stage_pkg::*;
(
    input  logic              lu_op,
    input  logic [1:0]        mem_to_reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [DATA_W-1:0] lu_data,
    output logic [DATA_W-1:0] wb_data
);

    always_comb begin
        wb_data = '0;
        if (lu_op) begin
            wb_data = lu_data;
        end else begin
            unique case (mem_to_reg)
                MTR_ALU:  wb_data = alu_result;
                MTR_MEM:  wb_data = mem_rdata;
                MTR_PC4:  wb_data = pc_plus4;
                MTR_ZERO: wb_data = '0;
                default:  wb_data = '0;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the 5-stage MIPS pipeline. Issues data-memory loads
// and stores over a req/ack handshake, stalls upstream while the memory is
// busy, abandons accesses that exceed TIMEOUT wait cycles, drops misaligned
// accesses, and registers the MEM/WB bus.
// Ports:
//   clk         in   1    pipeline clock
//   reset       in   1    synchronous active-high reset
//   EX_MEM      in  139   EX/MEM bus
//   dmem_req    out  1    memory request
//   dmem_we     out  1    1 = store, 0 = load
//   dmem_addr   out 32    byte address
//   dmem_wdata  out 32    store data
//   dmem_ack    in   1    memory completes the request this cycle
//   dmem_rdata  in  32    load data, valid with dmem_ack
//   mem_stall   out  1    freezes PC, IF/ID, ID/EX and EX/MEM
//   align_err   out  1    pulse: misaligned access dropped
//   bus_err     out  1    pulse: access timed out
//   MEM_WB      out 38    {RegWrite, dest, data}
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [EXM_W-1:0]  EX_MEM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_stall,
    output logic              align_err,
    output logic              bus_err,
    output logic [MWB_W-1:0]  MEM_WB
);

    // Field extraction
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] alu_result;
    logic [4:0]        dest;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic [1:0]        mem_to_reg;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] lu_data;
    logic              lu_op;

    assign store_data = EX_MEM[EXM_WDATA_LSB  +: DATA_W];
    assign alu_result = EX_MEM[EXM_ALU_LSB    +: DATA_W];
    assign dest       = EX_MEM[EXM_RD_LSB     +: 5];
    assign mem_read   = EX_MEM[EXM_MEMREAD];
    assign mem_write  = EX_MEM[EXM_MEMWRITE];
    assign reg_write  = EX_MEM[EXM_REGWRITE];
    assign mem_to_reg = EX_MEM[EXM_MTR_LSB    +: 2];
    assign pc_plus4   = EX_MEM[EXM_PC4_LSB    +: DATA_W];
    assign lu_data    = EX_MEM[EXM_LUDATA_LSB +: DATA_W];
    assign lu_op      = EX_MEM[EXM_LUOP];

    logic memop;
    assign memop = mem_read | mem_write;

    // A set MemWrite wins when both access bits are present
    assign dmem_we    = mem_write;
    assign dmem_addr  = alu_result;
    assign dmem_wdata = store_data;

    logic [DATA_W-1:0] wb_data;

    mem_wb_select u_sel (
        .lu_op      (lu_op),
        .mem_to_reg (mem_to_reg),
        .alu_result (alu_result),
        .mem_rdata  (dmem_rdata),
        .pc_plus4   (pc_plus4),
        .lu_data    (lu_data),
        .wb_data    (wb_data)
    );

    mem_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              timeout_hit;
    logic              misaligned;
    logic              capture;
    logic              wb_reg_write;
    logic [MWB_W-1:0]  mem_wb_p1;

    // Stores never write the register file; $zero is never written
    assign wb_reg_write = reg_write & (dest != 5'd0) & ~mem_write;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        timeout_hit = 1'b0;
        misaligned  = 1'b0;
        dmem_req    = 1'b0;
        mem_stall   = 1'b0;
        capture     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                misaligned = memop & (alu_result[1:0] != 2'b00);
                dmem_req   = ~reset & memop & ~misaligned;
                if (dmem_req && !dmem_ack) begin
                    state_next = ST_WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                timeout_hit = ~dmem_ack & (cnt == CNT_W'(TIMEOUT));
                // Request is withdrawn in the timeout cycle and in reset
                dmem_req    = ~reset & ~timeout_hit;
                if (dmem_ack || timeout_hit) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        mem_stall = dmem_req & ~dmem_ack & ~timeout_hit;
        // Stalled, timed-out and misaligned cycles all load a bubble
        capture   = ~mem_stall & ~timeout_hit & ~misaligned;
    end

    // Stage boundary: MEM -> WB register and control state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            align_err <= 1'b0;
            bus_err   <= 1'b0;
            mem_wb_p1 <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            align_err <= misaligned;
            bus_err   <= timeout_hit;
            mem_wb_p1 <= capture ? pack_mem_wb(wb_reg_write, dest, wb_data) : '0;
        end
    end

    assign MEM_WB = mem_wb_p1;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed self-checking bench for mem_stage.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic [138:0] EX_MEM;
    logic         dmem_req;
    logic         dmem_we;
    logic [31:0]  dmem_addr;
    logic [31:0]  dmem_wdata;
    logic         dmem_ack;
    logic [31:0]  dmem_rdata;
    logic         mem_stall;
    logic         align_err;
    logic         bus_err;
    logic [37:0]  MEM_WB;

    int passed = 0;
    int total  = 0;
    int stalls;

    mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .EX_MEM     (EX_MEM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .mem_stall  (mem_stall),
        .align_err  (align_err),
        .bus_err    (bus_err),
        .MEM_WB     (MEM_WB)
    );

    always #5 clk = ~clk;

    function automatic logic [138:0] mk(
        input logic [31:0] alu,
        input logic [31:0] wdata,
        input logic [4:0]  rd,
        input logic        mr,
        input logic        mw,
        input logic        rw,
        input logic [1:0]  mtr,
        input logic [31:0] pc4,
        input logic [31:0] lud,
        input logic        luop
    );
        return {luop, lud, pc4, mtr, rw, mw, mr, rd, alu, wdata};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample point: 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        EX_MEM     = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        tick();
        tick();
        chk("rst_mem_wb", 64'(MEM_WB), 64'h0);
        chk("rst_align", 64'(align_err), 64'h0);
        chk("rst_bus", 64'(bus_err), 64'h0);
        chk("rst_req", 64'(dmem_req), 64'h0);
        reset = 1'b0;

        // ALU op, no memory access
        EX_MEM = mk(32'h42, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("alu_stall", 64'(mem_stall), 64'h0);
        chk("alu_req", 64'(dmem_req), 64'h0);
        tick();
        chk("alu_wb", 64'(MEM_WB), 64'h25_0000_0042);

        // Zero-wait load
        EX_MEM = mk(32'h100, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 1'b0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld0_req", 64'(dmem_req), 64'h1);
        chk("ld0_we", 64'(dmem_we), 64'h0);
        chk("ld0_addr", 64'(dmem_addr), 64'h100);
        chk("ld0_stall", 64'(mem_stall), 64'h0);
        tick();
        chk("ld0_wb", 64'(MEM_WB), 64'h28_DEAD_BEEF);
        dmem_ack = 1'b0;

        // Store acknowledged after 3 wait cycles
        EX_MEM = mk(32'h200, 32'h12345678, 5'd3, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (mem_stall && dmem_req && dmem_we && dmem_wdata == 32'h12345678) stalls++;
            tick();
            chk("st_bubble", 64'(MEM_WB), 64'h0);
        end
        chk("st_stall_cycles", 64'(stalls), 64'd3);
        dmem_ack = 1'b1;
        #1;
        chk("st_ack_stall", 64'(mem_stall), 64'h0);
        chk("st_ack_req", 64'(dmem_req), 64'h1);
        tick();
        chk("st_wb_rw", 64'(MEM_WB[37]), 64'h0);
        dmem_ack = 1'b0;

        // Misaligned load
        EX_MEM = mk(32'h103, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 1'b0);
        #1;
        chk("mis_req", 64'(dmem_req), 64'h0);
        chk("mis_stall", 64'(mem_stall), 64'h0);
        tick();
        chk("mis_align", 64'(align_err), 64'h1);
        chk("mis_wb", 64'(MEM_WB), 64'h0);
        EX_MEM = mk(32'h11, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("mis_pulse_end", 64'(align_err), 64'h0);
        chk("mis_next_wb", 64'(MEM_WB), 64'h21_0000_0011);

        // Load that is never acknowledged
        EX_MEM = mk(32'h104, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 1'b0);
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!mem_stall) break;
            stalls++;
            tick();
        end
        chk("to_stall_cycles", 64'(stalls), 64'd16);
        chk("to_req_drop", 64'(dmem_req), 64'h0);
        tick();
        chk("to_bus_err", 64'(bus_err), 64'h1);
        chk("to_wb", 64'(MEM_WB), 64'h0);
        EX_MEM = mk(32'h77, 32'h0, 5'd6, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("to_next_stall", 64'(mem_stall), 64'h0);
        tick();
        chk("to_next_wb", 64'(MEM_WB), 64'h26_0000_0077);
        chk("to_bus_end", 64'(bus_err), 64'h0);

        // Reset in the second WAIT cycle
        EX_MEM = mk(32'h108, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 1'b0);
        #1;
        chk("rw_stall0", 64'(mem_stall), 64'h1);
        tick();
        tick();
        chk("rw_stall2", 64'(mem_stall), 64'h1);
        reset = 1'b1;
        #1;
        chk("rw_req_rst", 64'(dmem_req), 64'h0);
        tick();
        reset = 1'b0;
        chk("rw_wb", 64'(MEM_WB), 64'h0);
        chk("rw_bus", 64'(bus_err), 64'h0);
        chk("rw_align", 64'(align_err), 64'h0);
        // Still in IDLE: no ack keeps the new access stalled from its first cycle
        #1;
        chk("rw_idle_req", 64'(dmem_req), 64'h1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("rw_ld_stall", 64'(mem_stall), 64'h0);
        tick();
        chk("rw_ld_wb", 64'(MEM_WB), 64'h2A_CAFE_F00D);

        // LUOp overrides MemToReg=01
        EX_MEM = mk(32'h10, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 2'd1, 32'h0, 32'hABCD0000, 1'b1);
        dmem_rdata = 32'h11111111;
        tick();
        chk("luop_wb", 64'(MEM_WB), 64'h24_ABCD_0000);
        dmem_ack = 1'b0;

        // Destination $zero suppresses RegWrite
        EX_MEM = mk(32'h99, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("rd0_wb", 64'(MEM_WB), 64'h00_0000_0099);

        // MemToReg=10 selects PC+4
        EX_MEM = mk(32'h5, 32'h0, 5'd31, 1'b0, 1'b0, 1'b1, 2'd2, 32'h00400008, 32'h0, 1'b0);
        tick();
        chk("pc4_wb", 64'(MEM_WB), 64'h3F_0040_0008);

        // MemToReg=11 writes zero
        EX_MEM = mk(32'h5, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 2'd3, 32'h00400008, 32'h0, 1'b0);
        tick();
        chk("zero_wb", 64'(MEM_WB), 64'h22_0000_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
